// File: rtl/qpu_itcm_arbt_if.sv
// Fetch (ifu) and loader (ext) request/response handshakes that share the ITCM.
// master = requester side, slave = arbiter side.
interface qpu_itcm_arbt_if #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          ifu_cmd_valid;
  logic          ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          ifu_rsp_err;

  logic          ext_cmd_valid;
  logic          ext_cmd_ready;
  logic          ext_cmd_read;
  logic [AW-1:0] ext_cmd_addr;
  logic [DW-1:0] ext_cmd_wdata;
  logic [MW-1:0] ext_cmd_wmask;
  logic          ext_rsp_valid;
  logic          ext_rsp_ready;
  logic [DW-1:0] ext_rsp_rdata;
  logic          ext_rsp_err;

  modport master (
    output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
           ext_cmd_valid, ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask, ext_rsp_ready,
    input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
           ext_cmd_ready, ext_rsp_valid, ext_rsp_rdata, ext_rsp_err
  );

  modport slave (
    input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
           ext_cmd_valid, ext_cmd_read, ext_cmd_addr, ext_cmd_wdata, ext_cmd_wmask, ext_rsp_ready,
    output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
           ext_cmd_ready, ext_rsp_valid, ext_rsp_rdata, ext_rsp_err
  );
endinterface

// File: rtl/qpu_itcm_arbt.sv
// Round-robin arbiter/sequencer for the single-port QPU ITCM: one outstanding
// access, 1-cycle response with read-data bypass + hold, idle light-sleep.
module qpu_itcm_arbt #(
  parameter int          AW          = 16,
  parameter int          DW          = 64,
  parameter int          MW          = 8,
  parameter int unsigned DP          = 65536,
  parameter int          IDLE_LS_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  qpu_itcm_arbt_if.slave bus,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);
  typedef enum logic [1:0] {IDLE, PEND, SLEEP} state_e;

  localparam logic [7:0] LS_CYC = 8'(IDLE_LS_CYC);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rr_q, own_q, rd_q, err_q, first_q, ls_q;
  logic [DW-1:0] hold_q, rsp_data;
  logic [1:0]    vld;
  logic          any_vld, rsp_hs, can_gnt, gnt, gnt_ext, gnt_ifu, in_rng;

  assign vld     = {bus.ext_cmd_valid, bus.ifu_cmd_valid};
  assign any_vld = |vld;
  assign rsp_hs  = (state_q == PEND) & (own_q ? bus.ext_rsp_ready : bus.ifu_rsp_ready);
  // a retiring response frees the slot in the same cycle; never touch the RAM under reset
  assign can_gnt = ~rst & ((state_q == IDLE) | rsp_hs);
  assign gnt     = can_gnt & any_vld;
  assign gnt_ext = gnt & vld[1] & (~vld[0] | ~rr_q);
  assign gnt_ifu = gnt & ~gnt_ext;

  assign bus.ifu_cmd_ready = gnt_ifu;
  assign bus.ext_cmd_ready = gnt_ext;

  assign ram_addr = gnt_ext ? bus.ext_cmd_addr : bus.ifu_cmd_addr;
  assign in_rng   = 32'(ram_addr) < DP;
  assign ram_cs   = gnt & in_rng;
  assign ram_we   = ram_cs & gnt_ext & ~bus.ext_cmd_read;
  assign ram_wem  = gnt_ext ? bus.ext_cmd_wmask : '0;
  assign ram_din  = gnt_ext ? bus.ext_cmd_wdata : '0;
  assign ram_ls   = ls_q;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  // first response cycle forwards the RAM output; later cycles replay the hold copy
  assign rsp_data = (rd_q & ~err_q) ? (first_q ? ram_dout : hold_q) : '0;

  assign bus.ifu_rsp_valid = (state_q == PEND) & ~own_q;
  assign bus.ext_rsp_valid = (state_q == PEND) & own_q;
  assign bus.ifu_rsp_rdata = rsp_data;
  assign bus.ext_rsp_rdata = rsp_data;
  assign bus.ifu_rsp_err   = err_q;
  assign bus.ext_rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = PEND;
          cnt_d   = '0;
        end else if (cnt_q + 8'd1 == LS_CYC) begin
          state_d = SLEEP;
          cnt_d   = LS_CYC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PEND: begin
        cnt_d = '0;
        if (!gnt && rsp_hs) state_d = IDLE;
      end
      SLEEP: begin
        if (any_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ls_q    <= 1'b0;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ls_q    <= (state_d == SLEEP);
      first_q <= gnt;
      if (gnt) begin
        rr_q  <= gnt_ext;
        own_q <= gnt_ext;
        rd_q  <= gnt_ifu | bus.ext_cmd_read;
        err_q <= ~in_rng;
      end
      if (first_q) hold_q <= rsp_data;
    end
  end
endmodule

// File: tb/tb_qpu_itcm_arbt.sv
// Scoreboard bench for qpu_itcm_arbt: directed scenarios then randomized traffic,
// checked against a transaction-level model of arbitration, memory and sleep.
module tb_qpu_itcm_arbt;
  localparam int DP = 4096;
  localparam int LS = 16;

  typedef struct { logic [63:0] rdata; logic err; } exp_t;

  logic        clk, rst;
  logic        ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din;
  logic [63:0] ram_dout = '0;

  qpu_itcm_arbt_if #(.AW(16), .DW(64), .MW(8)) bus ();

  qpu_itcm_arbt #(.AW(16), .DW(64), .MW(8), .DP(DP), .IDLE_LS_CYC(LS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // SRAM device model: registered read, byte-masked write
  logic [63:0] ram_mem [int];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[int'(ram_addr)] = merge(ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0, ram_din, ram_wem);
      else ram_dout <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
    end
  end

  int   nvec = 0, nerr = 0;
  exp_t q_ifu[$], q_ext[$];
  logic [63:0] ref_mem [int];
  bit   m_out, m_own, m_last, m_ls;
  int   m_cnt;
  bit   ifu_taken, ext_taken;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor / reference model
  always @(negedge clk) begin
    bit hs, anyv, eg, ee, ei, wr, inr;
    logic [15:0] a;
    exp_t e;
    if (rst) begin
      chk("reset_outputs", {bus.ifu_cmd_ready, bus.ext_cmd_ready, bus.ifu_rsp_valid, bus.ext_rsp_valid,
                            ram_cs, ram_we, ram_ls, ram_ds, ram_sd}, 9'd0);
      q_ifu.delete(); q_ext.delete();
      m_out = 0; m_own = 0; m_last = 0; m_ls = 0; m_cnt = 0;
      ifu_taken = 0; ext_taken = 0;
    end else begin
      ifu_taken = bus.ifu_cmd_valid & bus.ifu_cmd_ready;
      ext_taken = bus.ext_cmd_valid & bus.ext_cmd_ready;
      chk("ram_ls", ram_ls, m_ls);
      chk("rsp_valid", {bus.ifu_rsp_valid, bus.ext_rsp_valid}, !m_out ? 2'b00 : (m_own ? 2'b01 : 2'b10));
      hs = m_out && (m_own ? bus.ext_rsp_ready : bus.ifu_rsp_ready);
      if (m_out && m_own && q_ext.size() > 0) begin
        chk("ext_rsp", {bus.ext_rsp_err, bus.ext_rsp_rdata}, {q_ext[0].err, q_ext[0].rdata});
        if (hs) e = q_ext.pop_front();
      end else if (m_out && !m_own && q_ifu.size() > 0) begin
        chk("ifu_rsp", {bus.ifu_rsp_err, bus.ifu_rsp_rdata}, {q_ifu[0].err, q_ifu[0].rdata});
        if (hs) e = q_ifu.pop_front();
      end
      anyv = bus.ifu_cmd_valid | bus.ext_cmd_valid;
      eg = anyv && !m_ls && (!m_out || hs);
      ee = eg && bus.ext_cmd_valid && (!bus.ifu_cmd_valid || !m_last);
      ei = eg && !ee;
      chk("cmd_ready", {bus.ifu_cmd_ready, bus.ext_cmd_ready}, {ei, ee});
      if (eg) begin
        a   = ee ? bus.ext_cmd_addr : bus.ifu_cmd_addr;
        inr = (int'(a) < DP);
        wr  = ee && !bus.ext_cmd_read;
        chk("ram_cs", ram_cs, inr);
        chk("ram_we", ram_we, wr && inr);
        if (inr) chk("ram_addr", ram_addr, a);
        if (ei) chk("ifu_wem", ram_wem, 8'h00);
        if (wr && inr) chk("ram_wdata", {ram_wem, ram_din}, {bus.ext_cmd_wmask, bus.ext_cmd_wdata});
        e.err   = !inr;
        e.rdata = (!wr && inr && ref_mem.exists(int'(a))) ? ref_mem[int'(a)] : '0;
        if (wr && inr)
          ref_mem[int'(a)] = merge(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0, bus.ext_cmd_wdata, bus.ext_cmd_wmask);
        if (ee) q_ext.push_back(e); else q_ifu.push_back(e);
        m_out = 1; m_own = ee; m_last = ee; m_cnt = 0;
      end else begin
        chk("ram_cs_nogrant", ram_cs, 1'b0);
        if (m_out && hs) m_out = 0;
        else if (m_ls) begin
          if (anyv) begin m_ls = 0; m_cnt = 0; end
        end else if (!m_out) begin
          m_cnt++;
          if (m_cnt == LS) m_ls = 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_taken(input bit ext, input string nm);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      got = ext ? ext_taken : ifu_taken;
    end
    nvec++;
    if (!got) begin nerr++; $display("FAIL %s_timeout: got no grant expected grant within 50 cycles", nm); end
  endtask

  task automatic issue(input bit ext, input bit rd, input logic [15:0] a, input logic [63:0] wd, input logic [7:0] wm);
    @(posedge clk); #1;
    if (ext) begin
      bus.ext_cmd_valid = 1; bus.ext_cmd_read = rd; bus.ext_cmd_addr = a;
      bus.ext_cmd_wdata = wd; bus.ext_cmd_wmask = wm;
    end else begin
      bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = a;
    end
    wait_taken(ext, ext ? "ext" : "ifu");
    if (ext) bus.ext_cmd_valid = 0; else bus.ifu_cmd_valid = 0;
  endtask

  function automatic logic [15:0] rnd_addr(input int oor);
    if (int'($urandom_range(99)) < oor) return 16'(DP + int'($urandom_range(65535 - DP)));
    return 16'($urandom_range(31));
  endfunction

  task automatic run_rand(input int n, input int pv, input int pr, input int oor);
    repeat (n) begin
      @(posedge clk); #1;
      if (!bus.ifu_cmd_valid || ifu_taken) begin
        bus.ifu_cmd_valid = (int'($urandom_range(99)) < pv);
        bus.ifu_cmd_addr  = rnd_addr(oor);
      end
      if (!bus.ext_cmd_valid || ext_taken) begin
        bus.ext_cmd_valid = (int'($urandom_range(99)) < pv);
        bus.ext_cmd_read  = 1'($urandom_range(1));
        bus.ext_cmd_addr  = rnd_addr(oor);
        bus.ext_cmd_wdata = {$urandom, $urandom};
        bus.ext_cmd_wmask = 8'($urandom);
      end
      bus.ifu_rsp_ready = (int'($urandom_range(99)) < pr);
      bus.ext_rsp_ready = (int'($urandom_range(99)) < pr);
    end
  endtask

  initial begin
    rst = 1;
    bus.ifu_cmd_valid = 0; bus.ifu_cmd_addr = '0; bus.ifu_rsp_ready = 1;
    bus.ext_cmd_valid = 0; bus.ext_cmd_read = 0; bus.ext_cmd_addr = '0;
    bus.ext_cmd_wdata = '0; bus.ext_cmd_wmask = '0; bus.ext_rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(20);                                              // light sleep after 16 idle cycles
    issue(1, 0, 16'h0010, 64'hDEADBEEF_CAFEF00D, 8'hFF);  // wakes, then writes
    issue(0, 1, 16'h0010, '0, '0);                         // reads back the write
    run_rand(4, 100, 100, 0);                              // contested: ext, ifu, ext, ifu
    bus.ifu_cmd_valid = 0; bus.ext_cmd_valid = 0;
    idle(2);
    bus.ifu_rsp_ready = 0;                                 // hold a read response 3 cycles
    issue(0, 1, 16'h0010, '0, '0);
    bus.ext_cmd_valid = 1; bus.ext_cmd_read = 1; bus.ext_cmd_addr = 16'h0011;
    idle(3);
    bus.ifu_rsp_ready = 1;
    wait_taken(1, "ext_after_hold");
    bus.ext_cmd_valid = 0;
    issue(1, 1, 16'hF000, '0, '0);                         // out of range
    idle(20);
    issue(0, 1, 16'h0010, '0, '0);                         // request while asleep
    for (int k = 0; k < 8; k++) begin
      run_rand(250, 20 + 10 * k, 40 + 8 * k, 5);
      if (k % 3 == 1) begin
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
      end
    end
    bus.ifu_cmd_valid = 0; bus.ext_cmd_valid = 0;
    bus.ifu_rsp_ready = 1; bus.ext_rsp_ready = 1;
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/qpu_itcm_arbt.md
Name: qpu_itcm_arbt

Overview:
- Arbiter and sequencer in front of the single-port QPU ITCM SRAM wrapper.
- Shares the RAM between two requesters:
  - the QPU instruction fetch port (port 0, read-only);
  - the external loader/bus port (port 1, read/write).
- Owns the RAM control pins (cs, we, addr, wem, din), captures read data into a held response, and manages light-sleep (ls) during idle periods.

Parameters:
- AW, 16, RAM word address width (matches QPU_ITCM_RAM_AW).
- DW, 64, RAM data width (matches QPU_ITCM_RAM_DW).
- MW, 8, write byte-mask width, DW/8 (matches QPU_ITCM_RAM_MW).
- DP, 65536, RAM depth in words; addresses >= DP are out of range.
- IDLE_LS_CYC, 16, consecutive idle cycles before ls asserts; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ifu_cmd_valid  in  1  fetch request valid.
- ifu_cmd_ready  out  1  fetch request accepted.
- ifu_cmd_addr  in  AW  fetch word address.
- ifu_rsp_valid  out  1  fetch response valid.
- ifu_rsp_ready  in  1  fetch response consumed.
- ifu_rsp_rdata  out  DW  fetch read data.
- ifu_rsp_err  out  1  fetch address out of range.
- ext_cmd_valid  in  1  external request valid.
- ext_cmd_ready  out  1  external request accepted.
- ext_cmd_read  in  1  1 = read, 0 = write.
- ext_cmd_addr  in  AW  external word address.
- ext_cmd_wdata  in  DW  write data.
- ext_cmd_wmask  in  MW  write byte enables.
- ext_rsp_valid  out  1  external response valid.
- ext_rsp_ready  in  1  external response consumed.
- ext_rsp_rdata  out  DW  external read data; 0 for writes.
- ext_rsp_err  out  1  external address out of range.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wem  out  MW  RAM write mask.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; valid the cycle after cs with ~we.
- ram_ls  out  1  light sleep.
- ram_ds  out  1  deep sleep, tied 0.
- ram_sd  out  1  shutdown, tied 0.

Behaviour:
- Reset values: all *_ready = 0, all *_rsp_valid = 0, ram_cs = 0, ram_we = 0, ram_ls = 0, hold data = 0, rr pointer = port 0, idle counter = 0, state = IDLE.
- States and transitions:
  - IDLE (no response outstanding) -> PEND on grant.
  - PEND (one response held) -> IDLE when the owning rsp_ready is seen, or back to PEND if a new grant occurs in the same cycle.
  - IDLE -> SLEEP when the idle counter reaches IDLE_LS_CYC.
  - SLEEP -> IDLE the cycle after any cmd_valid is seen.
- Single outstanding transaction:
  - A grant may issue in IDLE, or in PEND in the same cycle that the owner's rsp_valid & rsp_ready handshake completes (back-to-back throughput: one access per cycle).
  - No grant in SLEEP.
- Arbitration:
  - Round-robin: if both ports are valid, grant the port not granted last; rr pointer updates only on grant.
  - A single valid port is granted immediately.
  - cmd_ready is combinational, and high only for the granted port in its grant cycle.
- Grant cycle:
  - ram_cs = 1 only if addr < DP; ram_we = 1 for an ext write.
  - addr, wem and din are driven from the granted port; an IFU grant drives wem = 0.
  - Out-of-range: no RAM access; the response carries err = 1 and rdata = 0.
- Response:
  - rsp_valid for the owner rises the cycle after grant (1-cycle latency).
  - On that first cycle rsp_rdata = ram_dout (bypass), and the same value is captured into the hold register.
  - Later cycles present the hold register until rsp_ready.
  - Writes respond with rdata = 0, err = 0.
  - The non-owner's rsp_valid stays 0.
- Sleep:
  - The idle counter increments each cycle with no grant and no outstanding response, saturating at IDLE_LS_CYC.
  - At IDLE_LS_CYC, ram_ls = 1 (registered).
  - Any cmd_valid while ram_ls = 1 clears ram_ls next cycle (1-cycle wake penalty).
  - The counter clears on any grant.
- Reset mid-transaction: the outstanding response is dropped and the RAM is not accessed in the reset cycle.

Test Plan:
- Reset release, no traffic -> all outputs 0; ram_ls = 1 exactly 16 cycles after the first idle cycle.
- IFU read of addr 0x0010, after an ext write of wdata 0xDEADBEEF_CAFEF00D with wmask 0xFF -> ext_rsp_valid 1 cycle after grant with err = 0; ifu_rsp_rdata = 0xDEADBEEF_CAFEF00D.
- Both ports valid for 4 cycles, both rsp_ready = 1 -> grants alternate ext, ifu, ext, ifu (last grant before the burst was ifu); one grant per cycle.
- ifu_rsp_ready held 0 for 3 cycles after a read -> rdata stable across the hold; no further grant; ext_cmd_ready = 0 until the handshake completes.
- ext read of addr >= DP -> ram_cs stays 0; ext_rsp_err = 1; rdata = 0.
- Request arrives while ram_ls = 1 -> ram_ls drops next cycle; grant follows one cycle later; data correct.
